// File: rtl/eth_tx_fcs_ctrl_if.sv
// Byte-stream handshake bundle used on both sides of eth_tx_fcs_ctrl.
// master drives data/valid/last, slave drives ready.
interface eth_tx_fcs_ctrl_if;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       ready;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/eth_tx_fcs_ctrl.sv
// TX CRC32 sequencer: forwards a frame, pads it, and appends the FCS.
// Optional padding to MIN_LEN is enabled by defining TX_PAD_EN.
module eth_tx_fcs_ctrl #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514,
  parameter int LEN_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  eth_tx_fcs_ctrl_if.slave s,
  eth_tx_fcs_ctrl_if.master m,
  output logic             busy,
  output logic [LEN_W-1:0] frame_len,
  output logic             err_oversize
);

  localparam logic [31:0] POLY = 32'hEDB88320;
  localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_LEN);

`ifdef TX_PAD_EN
  localparam logic [LEN_W-1:0] MINL = LEN_W'(MIN_LEN);
  typedef enum logic [2:0] {
    IDLE, DATA, PAD, FCS, DROP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, DATA, FCS, DROP
  } state_t;
`endif

  state_t           state;
  state_t           end_st;
  logic [31:0]      crc;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] cnt_inc;
  logic [1:0]       fcs_idx;
  logic [7:0]       fcs_byte;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             last_q;
  logic             adv;
  logic             acc;

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  assign adv = !valid_q || m.ready;

  assign s.ready = !rst && (
    (state == DROP) ||
    (((state == IDLE) || (state == DATA)) && adv));

  assign acc = s.valid && s.ready;

  assign cnt_inc = (count < MAXL) ?
    count + LEN_W'(1) : count;

  assign m.data  = data_q;
  assign m.valid = valid_q;
  assign m.last  = last_q;

  assign busy = (state != IDLE) || valid_q;

  // End-of-data decision, taken in the cycle of the last accept
`ifdef TX_PAD_EN
  logic [LEN_W-1:0] nxt_cnt;
  always_comb begin
    nxt_cnt = (state == IDLE) ? LEN_W'(1) : cnt_inc;
    end_st  = (nxt_cnt < MINL) ? PAD : FCS;
  end
`else
  assign end_st = FCS;
`endif

  // FCS is the complemented CRC, low byte first
  always_comb begin
    fcs_byte = 8'h00;
    unique case (fcs_idx)
      2'd0: fcs_byte = ~crc[7:0];
      2'd1: fcs_byte = ~crc[15:8];
      2'd2: fcs_byte = ~crc[23:16];
      2'd3: fcs_byte = ~crc[31:24];
      default: fcs_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      crc          <= '1;
      count        <= '0;
      fcs_idx      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      frame_len    <= '0;
      err_oversize <= 1'b0;
    end else begin
      err_oversize <= 1'b0;
      if (adv) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (acc) begin
            crc     <= crc_upd('1, s.data);
            count   <= LEN_W'(1);
            data_q  <= s.data;
            valid_q <= 1'b1;
            state   <= s.last ? end_st : DATA;
          end
        end
        DATA: begin
          if (acc) begin
            crc     <= crc_upd(crc, s.data);
            count   <= cnt_inc;
            data_q  <= s.data;
            valid_q <= 1'b1;
            if (s.last) begin
              state <= end_st;
            end else if (cnt_inc == MAXL) begin
              err_oversize <= 1'b1;
              last_q       <= 1'b1;
              state        <= DROP;
            end
          end
        end
`ifdef TX_PAD_EN
        PAD: begin
          if (adv) begin
            crc     <= crc_upd(crc, 8'h00);
            count   <= cnt_inc;
            data_q  <= 8'h00;
            valid_q <= 1'b1;
            if (cnt_inc == MINL)
              state <= FCS;
          end
        end
`endif
        FCS: begin
          if (adv) begin
            data_q  <= fcs_byte;
            valid_q <= 1'b1;
            last_q  <= (fcs_idx == 2'd3);
            fcs_idx <= fcs_idx + 2'd1;
            if (fcs_idx == 2'd3) begin
              frame_len <= count;
              state     <= IDLE;
            end
          end
        end
        DROP: begin
          if (s.valid && s.last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Scoreboard bench for eth_tx_fcs_ctrl: directed frames in,
// expected bytes queued, a negedge monitor pops and compares.
module tb_eth_tx_fcs_ctrl;
  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;
  localparam int LEN_W   = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  eth_tx_fcs_ctrl_if sif();
  eth_tx_fcs_ctrl_if mif();

  logic             busy;
  logic [LEN_W-1:0] frame_len;
  logic             err_oversize;

  eth_tx_fcs_ctrl #(
    .MIN_LEN(MIN_LEN),
    .MAX_LEN(MAX_LEN),
    .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s(sif.slave),
    .m(mif.master),
    .busy(busy),
    .frame_len(frame_len),
    .err_oversize(err_oversize)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   last_cyc[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   first_cyc = -1;
  int   err_seen  = 0;
  int   xfers     = 0;
  bit   tog       = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] crc_b(input logic [31:0] c,
                                        input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Expected output of one good frame; returns expected frame_len
  task automatic push_frame(input logic [7:0] f[$], output int len);
    logic [7:0]  o[$];
    logic [31:0] c;
    o = f;
`ifdef TX_PAD_EN
    while (o.size() < MIN_LEN) o.push_back(8'h00);
`endif
    c = '1;
    foreach (o[i]) begin
      c = crc_b(c, o[i]);
      exp_q.push_back('{d: o[i], l: 1'b0});
    end
    c = ~c;
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{d: c[8*k +: 8], l: (k == 3)});
    len = o.size();
  endtask

  // "123456789" with its known FCS bytes
  task automatic push_digits(input logic [7:0] f[$], output int len);
`ifdef TX_PAD_EN
    push_frame(f, len);
`else
    foreach (f[i]) exp_q.push_back('{d: f[i], l: 1'b0});
    exp_q.push_back('{d: 8'h26, l: 1'b0});
    exp_q.push_back('{d: 8'h39, l: 1'b0});
    exp_q.push_back('{d: 8'hF4, l: 1'b0});
    exp_q.push_back('{d: 8'hCB, l: 1'b1});
    len = 9;
`endif
  endtask

  initial begin
    mif.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mif.ready = tog ? ~mif.ready : 1'b1;
    end
  end

  initial begin : monitor
    logic       pstall;
    logic [7:0] pd;
    logic       pl;
    exp_t       e;
    pstall = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pstall = 1'b0;
      end else begin
        if (pstall)
          chk("stall_hold", {23'd0, mif.valid, mif.last, mif.data},
              {23'd0, 1'b1, pl, pd});
        if (mif.valid && mif.ready) begin
          xfers++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none",
                     mif.data);
          end else begin
            e = exp_q.pop_front();
            chk("out_byte", {23'd0, mif.last, mif.data},
                {23'd0, e.l, e.d});
          end
          if (mif.last) last_cyc.push_back(cyc);
        end
        pstall = mif.valid && !mif.ready;
        pd = mif.data;
        pl = mif.last;
        if (err_oversize) err_seen++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l,
                           input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      sif.valid = 1'b0;
    end
    @(posedge clk);
    #1;
    sif.data  = d;
    sif.valid = 1'b1;
    sif.last  = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (sif.ready) break;
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL s_ready_timeout: got 0 expected 1");
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gaps,
                            input bit mark);
    foreach (f[i]) begin
      send_byte(f[i], i == f.size() - 1,
                gaps ? int'($urandom_range(0, 2)) : 0);
      if (mark && i == 0) first_cyc = cyc;
    end
  endtask

  task automatic idle_in();
    @(posedge clk);
    #1;
    sif.valid = 1'b0;
    sif.last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_busy"}, {31'd0, busy}, 0);
    chk({name, "_queue"}, exp_q.size(), 0);
  endtask

  initial begin : stim
    logic [7:0] dig[$];
    logic [7:0] f64[$];
    logic [7:0] fa[$];
    logic [7:0] fb[$];
    logic [7:0] f20[$];
    int len;
    int len2;
    int x0;

    sif.data  = '0;
    sif.valid = 1'b0;
    sif.last  = 1'b0;
    for (int i = 0; i < 9; i++) dig.push_back(8'(8'h31 + i));
    for (int i = 0; i < 64; i++) f64.push_back(8'(i * 7 + 3));
    for (int i = 0; i < 60; i++) fa.push_back(8'(i ^ 8'h5A));
    for (int i = 0; i < 60; i++) fb.push_back(8'(i + 8'h80));
    for (int i = 0; i < 20; i++) f20.push_back(8'(i + 1));

    #1 rst = 1'b1;
    #2;
    chk("rst_s_ready", {31'd0, sif.ready}, 0);
    chk("rst_m_valid", {31'd0, mif.valid}, 0);
    chk("rst_m_last", {31'd0, mif.last}, 0);
    chk("rst_m_data", {24'd0, mif.data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_frame_len", {20'd0, frame_len}, 0);
    chk("rst_err", {31'd0, err_oversize}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    push_digits(dig, len);
    send_frame(dig, 1'b0, 1'b0);
    idle_in();
    wait_drain("digits");
    chk("digits_frame_len", {20'd0, frame_len}, len);

    tog = 1'b1;
    x0 = xfers;
    push_frame(f64, len);
    send_frame(f64, 1'b1, 1'b0);
    idle_in();
    wait_drain("stall64");
    tog = 1'b0;
    chk("stall64_xfers", xfers - x0, 68);
    chk("stall64_frame_len", {20'd0, frame_len}, len);

    last_cyc.delete();
    push_frame(fa, len);
    push_frame(fb, len2);
    send_frame(fa, 1'b0, 1'b0);
    send_frame(fb, 1'b0, 1'b1);
    idle_in();
    wait_drain("b2b");
    chk("b2b_last_count", last_cyc.size(), 2);
    if (last_cyc.size() > 0)
      chk("b2b_same_cycle", first_cyc, last_cyc[0]);
    chk("b2b_frame_len", {20'd0, frame_len}, len2);

    err_seen = 0;
    for (int i = 0; i < MAX_LEN; i++)
      exp_q.push_back('{d: 8'(i * 3), l: (i == MAX_LEN - 1)});
    for (int i = 0; i < 1600; i++)
      send_byte(8'(i * 3), i == 1599, 0);
    idle_in();
    wait_drain("oversize");
    chk("oversize_pulses", err_seen, 1);
    chk("oversize_frame_len", {20'd0, frame_len}, len2);

    foreach (f20[i]) exp_q.push_back('{d: f20[i], l: 1'b0});
    for (int i = 0; i < 20; i++) send_byte(f20[i], 1'b0, 0);
    @(posedge clk);
    #2;
    chk("mid_m_valid", {31'd0, mif.valid}, 1);
    rst = 1'b1;
    #1;
    chk("arst_m_valid", {31'd0, mif.valid}, 0);
    chk("arst_m_data", {24'd0, mif.data}, 0);
    chk("arst_m_last", {31'd0, mif.last}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_s_ready", {31'd0, sif.ready}, 0);
    chk("arst_frame_len", {20'd0, frame_len}, 0);
    sif.valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    push_digits(dig, len);
    send_frame(dig, 1'b0, 1'b0);
    idle_in();
    wait_drain("reseed");
    chk("reseed_frame_len", {20'd0, frame_len}, len);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
